// File: rtl/vga_sync_gen.sv
// VGA timing decoder and pixel pipeline: turns pixel/line counter values into
// registered sync, blanking and RGB332 pixels fetched from a scaled framebuffer.
module vga_sync_gen #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter bit HSYNC_POL   = 1'b0,
  parameter bit VSYNC_POL   = 1'b0,
  parameter int SCALE_SHIFT = 2,
  parameter int ADDR_WIDTH  = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [9:0]            pixel_counter,
  input  logic [9:0]            line_counter,
  input  logic [1:0]            sub_pixel_counter,
  output logic [ADDR_WIDTH-1:0] fb_addr,
  output logic                  fb_rd_en,
  input  logic [7:0]            fb_data,
  output logic                  vga_hsync,
  output logic                  vga_vsync,
  output logic [2:0]            vga_r,
  output logic [2:0]            vga_g,
  output logic [1:0]            vga_b,
  output logic                  frame_start,
  output logic                  in_vblank
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_VIS_C      = 10'(H_VISIBLE);
  localparam logic [9:0] H_SYNC_BEG_C = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] H_SYNC_END_C = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] H_TOTAL_C    = 10'(H_TOTAL);
  localparam logic [9:0] V_VIS_C      = 10'(V_VISIBLE);
  localparam logic [9:0] V_SYNC_BEG_C = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] V_SYNC_END_C = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [9:0] V_TOTAL_C    = 10'(V_TOTAL);

  localparam logic [ADDR_WIDTH-1:0] FB_WIDTH_C = ADDR_WIDTH'(H_VISIBLE >> SCALE_SHIFT);

  // enable low is treated exactly like reset, so one clear covers both
  logic clear;
  assign clear = reset | ~enable;

  // ---------------------------------------------------------------------------
  // Counter decode (combinational, consumed only on stage-A clocks)
  // ---------------------------------------------------------------------------
  logic                  stage_a_fire;
  logic                  stage_c_fire;
  logic                  in_range;
  logic                  visible;
  logic                  hs_act;
  logic                  vs_act;
  logic [ADDR_WIDTH-1:0] row_a;
  logic [ADDR_WIDTH-1:0] col_a;
  logic [ADDR_WIDTH-1:0] addr_calc;

  // Low-order bits of a product/sum depend only on low-order operand bits,
  // so evaluating at address width equals the full-width result truncated.
  always_comb begin
    in_range  = (pixel_counter < H_TOTAL_C) && (line_counter < V_TOTAL_C);
    visible   = (pixel_counter < H_VIS_C) && (line_counter < V_VIS_C);
    hs_act    = in_range && (pixel_counter >= H_SYNC_BEG_C) && (pixel_counter < H_SYNC_END_C);
    vs_act    = in_range && (line_counter >= V_SYNC_BEG_C) && (line_counter < V_SYNC_END_C);
    row_a     = ADDR_WIDTH'(line_counter >> SCALE_SHIFT);
    col_a     = ADDR_WIDTH'(pixel_counter >> SCALE_SHIFT);
    addr_calc = row_a * FB_WIDTH_C + col_a;
  end

  // ---------------------------------------------------------------------------
  // Pipeline state
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] fb_addr_q, fb_addr_d;
  logic                  fb_rd_en_q, fb_rd_en_d;
  logic                  frame_start_q, frame_start_d;
  logic                  in_vblank_q, in_vblank_d;
  logic                  a_valid_q, a_valid_d;
  logic                  vis_a_q, vis_a_d;
  logic                  hs_a_q, hs_a_d;
  logic                  vs_a_q, vs_a_d;
  logic                  b_valid_q, b_valid_d;
  logic                  vis_b_q, vis_b_d;
  logic                  hs_b_q, hs_b_d;
  logic                  vs_b_q, vs_b_d;
  logic [7:0]            rgb_q, rgb_d;
  logic                  hsync_q, hsync_d;
  logic                  vsync_q, vsync_d;

  assign stage_a_fire = (sub_pixel_counter == 2'd0);
  // Read data lands one clk after the strobe, i.e. on the sub==2 clock
  assign stage_c_fire = (sub_pixel_counter == 2'd2) && b_valid_q;

  always_comb begin
    fb_addr_d     = fb_addr_q;
    fb_rd_en_d    = 1'b0;
    frame_start_d = 1'b0;
    in_vblank_d   = in_vblank_q;
    a_valid_d     = 1'b0;
    vis_a_d       = vis_a_q;
    hs_a_d        = hs_a_q;
    vs_a_d        = vs_a_q;
    b_valid_d     = a_valid_q;
    vis_b_d       = vis_b_q;
    hs_b_d        = hs_b_q;
    vs_b_d        = vs_b_q;
    rgb_d         = rgb_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;

    if (stage_a_fire) begin
      a_valid_d     = 1'b1;
      vis_a_d       = visible;
      hs_a_d        = hs_act;
      vs_a_d        = vs_act;
      fb_rd_en_d    = visible;
      frame_start_d = (pixel_counter == 10'd0) && (line_counter == 10'd0);
      in_vblank_d   = (line_counter >= V_VIS_C);
      if (visible) begin
        fb_addr_d = addr_calc;
      end
    end

    if (a_valid_q) begin
      vis_b_d = vis_a_q;
      hs_b_d  = hs_a_q;
      vs_b_d  = vs_a_q;
    end

    if (stage_c_fire) begin
      rgb_d   = vis_b_q ? fb_data : 8'h00;
      hsync_d = hs_b_q ? HSYNC_POL : ~HSYNC_POL;
      vsync_d = vs_b_q ? VSYNC_POL : ~VSYNC_POL;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      fb_addr_q     <= '0;
      fb_rd_en_q    <= 1'b0;
      frame_start_q <= 1'b0;
      in_vblank_q   <= 1'b0;
      a_valid_q     <= 1'b0;
      vis_a_q       <= 1'b0;
      hs_a_q        <= 1'b0;
      vs_a_q        <= 1'b0;
      b_valid_q     <= 1'b0;
      vis_b_q       <= 1'b0;
      hs_b_q        <= 1'b0;
      vs_b_q        <= 1'b0;
      rgb_q         <= 8'h00;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
    end else begin
      fb_addr_q     <= fb_addr_d;
      fb_rd_en_q    <= fb_rd_en_d;
      frame_start_q <= frame_start_d;
      in_vblank_q   <= in_vblank_d;
      a_valid_q     <= a_valid_d;
      vis_a_q       <= vis_a_d;
      hs_a_q        <= hs_a_d;
      vs_a_q        <= vs_a_d;
      b_valid_q     <= b_valid_d;
      vis_b_q       <= vis_b_d;
      hs_b_q        <= hs_b_d;
      vs_b_q        <= vs_b_d;
      rgb_q         <= rgb_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
    end
  end

  assign fb_addr     = fb_addr_q;
  assign fb_rd_en    = fb_rd_en_q;
  assign frame_start = frame_start_q;
  assign in_vblank   = in_vblank_q;
  assign vga_r       = rgb_q[7:5];
  assign vga_g       = rgb_q[4:2];
  assign vga_b       = rgb_q[1:0];
  assign vga_hsync   = hsync_q;
  assign vga_vsync   = vsync_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: counters and a synchronous-read framebuffer
// model are driven from the bench; expectations are hand-derived.
module tb_vga_sync_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [9:0]  pix;
  logic [9:0]  lin;
  logic [1:0]  sub;
  logic [14:0] fb_addr;
  logic        fb_rd_en;
  logic [7:0]  fb_data = 8'h00;
  logic        vga_hsync;
  logic        vga_vsync;
  logic [2:0]  vga_r;
  logic [2:0]  vga_g;
  logic [1:0]  vga_b;
  logic        frame_start;
  logic        in_vblank;
  logic [7:0]  rgb;

  int errors = 0;
  int checks = 0;
  bit use_const = 1'b0;

  // clock / reset block
  always #5 clk = ~clk;

  vga_sync_gen dut (
    .clk(clk), .reset(reset), .enable(enable),
    .pixel_counter(pix), .line_counter(lin), .sub_pixel_counter(sub),
    .fb_addr(fb_addr), .fb_rd_en(fb_rd_en), .fb_data(fb_data),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .frame_start(frame_start), .in_vblank(in_vblank)
  );

  assign rgb = {vga_r, vga_g, vga_b};

  function automatic logic [7:0] mem_f(input logic [14:0] a);
    return a[7:0] + 8'h5A;
  endfunction

  // synchronous-read framebuffer: data one clk after the strobe
  always @(posedge clk) begin
    if (fb_rd_en) fb_data <= use_const ? 8'hE3 : mem_f(fb_addr);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input int l, input int s);
    pix = 10'(p);
    lin = 10'(l);
    sub = 2'(s);
  endtask

  // one full pixel period at (p,l); checks stage-A outputs and the pipelined outputs
  task automatic px(input int p, input int l, input logic [14:0] ea, input logic erd,
                    input logic efs, input logic evb, input logic [7:0] ergb,
                    input logic ehs, input logic evs);
    logic [14:0] a0;
    logic        rd0, fs0, vb0, extra, hs0, vs0;
    logic [7:0]  c0;
    drive(p, l, 0); tick();
    a0 = fb_addr; rd0 = fb_rd_en; fs0 = frame_start; vb0 = in_vblank;
    drive(p, l, 1); tick();
    extra = fb_rd_en | frame_start;
    drive(p, l, 2); tick();
    c0 = rgb; hs0 = vga_hsync; vs0 = vga_vsync;
    extra = extra | fb_rd_en | frame_start;
    drive(p, l, 3); tick();
    extra = extra | fb_rd_en | frame_start;
    chk($sformatf("addr p%0d l%0d", p, l), 32'(a0), 32'(ea));
    chk($sformatf("addr_hold p%0d l%0d", p, l), 32'(fb_addr), 32'(ea));
    chk($sformatf("rd_en p%0d l%0d", p, l), 32'(rd0), 32'(erd));
    chk($sformatf("frame_start p%0d l%0d", p, l), 32'(fs0), 32'(efs));
    chk($sformatf("in_vblank p%0d l%0d", p, l), 32'(vb0), 32'(evb));
    chk($sformatf("pulse_width p%0d l%0d", p, l), 32'(extra), 32'(0));
    chk($sformatf("rgb p%0d l%0d", p, l), 32'(c0), 32'(ergb));
    chk($sformatf("rgb_hold p%0d l%0d", p, l), 32'(rgb), 32'(ergb));
    chk($sformatf("hsync p%0d l%0d", p, l), 32'(hs0), 32'(ehs));
    chk($sformatf("vsync p%0d l%0d", p, l), 32'(vs0), 32'(evs));
  endtask

  initial begin
    int hs_cnt, hs_first, rd_cnt, fs_cnt, fs_n, vs_cnt, vs_first, q, m;
    logic [7:0] exp_rgb;
    logic       exp_hs;

    // ---- reset with counters free-running ----
    reset = 1'b1; enable = 1'b1;
    drive(650, 489, 0);
    for (int i = 0; i < 24; i++) begin
      tick();
      chk("rst_hsync", 32'(vga_hsync), 32'(1));
      chk("rst_vsync", 32'(vga_vsync), 32'(1));
      chk("rst_rgb", 32'(rgb), 32'(0));
      chk("rst_rd_en", 32'(fb_rd_en), 32'(0));
      chk("rst_addr", 32'(fb_addr), 32'(0));
      chk("rst_fs", 32'(frame_start), 32'(0));
      chk("rst_vblank", 32'(in_vblank), 32'(0));
      drive(650 + (i + 1) / 4, 489, (i + 1) % 4);
    end

    // ---- line 0, constant pixel data 8'hE3 ----
    reset = 1'b0; use_const = 1'b1;
    hs_cnt = 0; hs_first = -1; rd_cnt = 0; fs_cnt = 0; fs_n = -1; vs_cnt = 0;
    drive(0, 0, 0);
    for (int n = 0; n < 3202; n++) begin
      tick();
      if (n < 3200) begin
        if (fb_rd_en) rd_cnt++;
        if (frame_start) begin fs_cnt++; fs_n = n; end
      end
      if (!vga_vsync) vs_cnt++;
      if (n >= 2) begin
        q = (n - 2) / 4;
        exp_rgb = (q < 640) ? 8'hE3 : 8'h00;
        exp_hs  = !(q >= 656 && q < 752);
        if (!vga_hsync) begin
          hs_cnt++;
          if (hs_first < 0) hs_first = n;
        end
      end else begin
        exp_rgb = 8'h00;
        exp_hs  = 1'b1;
      end
      chk($sformatf("line0_rgb n%0d", n), 32'(rgb), 32'(exp_rgb));
      chk($sformatf("line0_hsync n%0d", n), 32'(vga_hsync), 32'(exp_hs));
      m = n + 1;
      drive((m / 4) % 800, m / 3200, m % 4);
    end
    chk("line0_hsync_low_clks", 32'(hs_cnt), 32'(384));
    chk("line0_hsync_first_edge", 32'(hs_first), 32'(2626));
    chk("line0_rd_en_count", 32'(rd_cnt), 32'(640));
    chk("line0_frame_start_count", 32'(fs_cnt), 32'(1));
    chk("line0_frame_start_at", 32'(fs_n), 32'(0));
    chk("line0_vsync_low_clks", 32'(vs_cnt), 32'(0));
    chk("line0_in_vblank", 32'(in_vblank), 32'(0));

    // ---- addresses on line 4, address-dependent data ----
    use_const = 1'b0;
    px(0,   4, 15'd160, 1'b1, 1'b0, 1'b0, mem_f(15'd160), 1'b1, 1'b1);
    px(1,   4, 15'd160, 1'b1, 1'b0, 1'b0, mem_f(15'd160), 1'b1, 1'b1);
    px(3,   4, 15'd160, 1'b1, 1'b0, 1'b0, mem_f(15'd160), 1'b1, 1'b1);
    px(4,   4, 15'd161, 1'b1, 1'b0, 1'b0, mem_f(15'd161), 1'b1, 1'b1);
    px(639, 4, 15'd319, 1'b1, 1'b0, 1'b0, mem_f(15'd319), 1'b1, 1'b1);
    px(640, 4, 15'd319, 1'b0, 1'b0, 1'b0, 8'h00,          1'b1, 1'b1);
    px(700, 4, 15'd319, 1'b0, 1'b0, 1'b0, 8'h00,          1'b0, 1'b1);

    // ---- frame landmarks ----
    px(639, 479, 15'd19199, 1'b1, 1'b0, 1'b0, mem_f(15'd19199), 1'b1, 1'b1);
    px(0,   480, 15'd19199, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
    px(0,   489, 15'd19199, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
    px(0,   490, 15'd19199, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    px(799, 491, 15'd19199, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    px(0,   492, 15'd19199, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
    px(0,   524, 15'd19199, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
    px(0,   0,   15'd0,     1'b1, 1'b1, 1'b0, mem_f(15'd0), 1'b1, 1'b1);
    px(1,   0,   15'd0,     1'b1, 1'b0, 1'b0, mem_f(15'd0), 1'b1, 1'b1);
    px(0,   1,   15'd0,     1'b1, 1'b0, 1'b0, mem_f(15'd0), 1'b1, 1'b1);

    // ---- lines 489..492 run continuously: vsync width ----
    vs_cnt = 0; vs_first = -1; rd_cnt = 0;
    for (int n = 0; n < 12802; n++) begin
      drive((n / 4) % 800, 489 + n / 3200, n % 4);
      tick();
      if (!vga_vsync) begin
        vs_cnt++;
        if (vs_first < 0) vs_first = n;
      end
      if (fb_rd_en) rd_cnt++;
    end
    chk("vsync_low_clks", 32'(vs_cnt), 32'(6400));
    chk("vsync_first_edge", 32'(vs_first), 32'(3202));
    chk("vblank_rd_en_count", 32'(rd_cnt), 32'(0));
    chk("vblank_in_vblank", 32'(in_vblank), 32'(1));

    // ---- out-of-range counters ----
    px(100, 600, 15'd0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
    px(700, 600, 15'd0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
    px(900, 490, 15'd0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
    px(900, 10,  15'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

    // ---- enable drop at line 100 pixel 300 ----
    drive(300, 100, 0); tick();
    chk("pre_drop_rd_en", 32'(fb_rd_en), 32'(1));
    chk("pre_drop_addr", 32'(fb_addr), 32'(4075));
    drive(300, 100, 1); tick();
    drive(300, 100, 2); tick();
    chk("pre_drop_rgb", 32'(rgb), 32'(mem_f(15'd4075)));
    drive(300, 100, 3); tick();
    drive(301, 100, 0); tick();
    chk("pre_drop_rd_en2", 32'(fb_rd_en), 32'(1));
    enable = 1'b0;
    drive(301, 100, 1); tick();
    chk("drop_rd_en", 32'(fb_rd_en), 32'(0));
    chk("drop_addr", 32'(fb_addr), 32'(0));
    chk("drop_rgb", 32'(rgb), 32'(0));
    chk("drop_hsync", 32'(vga_hsync), 32'(1));
    chk("drop_vsync", 32'(vga_vsync), 32'(1));
    chk("drop_vblank", 32'(in_vblank), 32'(0));
    drive(301, 100, 2); tick();
    chk("drop_no_stale_rgb", 32'(rgb), 32'(0));
    for (int i = 0; i < 5; i++) begin
      drive(302, 100, i % 4); tick();
    end
    enable = 1'b1;
    drive(0, 0, 0); tick();
    chk("resume_frame_start", 32'(frame_start), 32'(1));
    chk("resume_rd_en", 32'(fb_rd_en), 32'(1));
    chk("resume_addr", 32'(fb_addr), 32'(0));
    chk("resume_rgb0", 32'(rgb), 32'(0));
    drive(0, 0, 1); tick();
    chk("resume_frame_start_off", 32'(frame_start), 32'(0));
    chk("resume_rd_en_off", 32'(fb_rd_en), 32'(0));
    chk("resume_rgb1", 32'(rgb), 32'(0));
    drive(0, 0, 2); tick();
    chk("resume_rgb2", 32'(rgb), 32'(mem_f(15'd0)));
    drive(0, 0, 3); tick();

    // ---- drop enable while a captured read is in flight ----
    drive(10, 10, 0); tick();
    drive(10, 10, 1); tick();
    enable = 1'b0;
    drive(10, 10, 2); tick();
    chk("inflight_drop_rgb", 32'(rgb), 32'(0));
    enable = 1'b1;
    drive(11, 10, 2); tick();
    chk("inflight_resume_rgb", 32'(rgb), 32'(0));
    chk("inflight_resume_hsync", 32'(vga_hsync), 32'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
